// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 16-way round-robin arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux16_1.sv
// 16:1 single-bit select mux whose select is owned by the round-robin arbiter.
module mux16_1
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] data_in,
    input  logic [SEL_W-1:0] sel,
    output logic             data_out
);

    assign data_out = data_in[sel];

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set request at or after 'start', wrapping 15 -> 0.
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // rot[k] is the request sitting k places after start, so bit 0 has top priority.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            localparam logic [SEL_W-1:0] OFF = SEL_W'(gi);
            assign rot[gi] = req[start + OFF];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign found = |rot;
    assign idx   = start + off;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner selection for a shared 16:1 mux, with registered one-hot grant,
// select, valid qualifier and an optional bound on each owner's tenure.
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic [SEL_W-1:0] owner_cycles
);

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [SEL_W-1:0] HOLD_LAST = SEL_W'(HOLD_EN ? MAX_HOLD - 1 : 0);
    localparam logic [SEL_W-1:0] CYC_SAT   = '1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] owner_cycles_q, owner_cycles_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] next_after_owner;
    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             hold_hit;
    logic             release_now;

    assign next_after_owner = sel_q + SEL_W'(1);

    // Starting just past the owner makes the owner itself the last candidate.
    assign pick_start = (state_q == GRANT) ? next_after_owner : ptr_q;

    rr_pick16 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_hit    = HOLD_EN && (owner_cycles_q == HOLD_LAST);
    assign release_now = !req[sel_q] || hold_hit;

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        sel_d          = sel_q;
        valid_d        = valid_q;
        owner_cycles_d = owner_cycles_q;
        ptr_d          = ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d        = GRANT;
                    gnt_d          = onehot16(pick_idx);
                    sel_d          = pick_idx;
                    valid_d        = 1'b1;
                    owner_cycles_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = next_after_owner;
                    if (pick_found) begin
                        gnt_d          = onehot16(pick_idx);
                        sel_d          = pick_idx;
                        owner_cycles_d = '0;
                    end else begin
                        // sel is left on the last owner so the mux output does not glitch.
                        state_d        = IDLE;
                        gnt_d          = '0;
                        valid_d        = 1'b0;
                        owner_cycles_d = '0;
                    end
                end else if (owner_cycles_q != CYC_SAT) begin
                    owner_cycles_d = owner_cycles_q + SEL_W'(1);
                end
            end
            default: begin
                state_d        = IDLE;
                gnt_d          = '0;
                valid_d        = 1'b0;
                owner_cycles_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            sel_q          <= '0;
            valid_q        <= 1'b0;
            owner_cycles_q <= '0;
            ptr_q          <= '0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            sel_q          <= sel_d;
            valid_q        <= valid_d;
            owner_cycles_q <= owner_cycles_d;
            ptr_q          <= ptr_d;
        end
    end

    assign gnt          = gnt_q;
    assign sel          = sel_q;
    assign valid        = valid_q;
    assign owner_cycles = owner_cycles_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench: three arbiter instances (hold limits 8, 1, unlimited) against a
// behavioural round-robin model, plus directed scenarios with literal expectations.
module tb_mux16_rr_arbiter;

    typedef struct packed {
        int owner;
        int sel;
        int ptr;
        int cyc;
    } mstate_t;

    logic        clk;
    logic        reset;
    logic [15:0] req;

    logic [15:0] gnt8, gnt1, gnt0;
    logic [3:0]  sel8, sel1, sel0;
    logic        valid8, valid1, valid0;
    logic [3:0]  cyc8, cyc1, cyc0;

    logic [15:0] mux_in;
    logic        mux_out;

    mstate_t m8, m1, m0;
    bit      chk_en;
    int      vectors;
    int      fails;

    mux16_rr_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt8), .sel(sel8), .valid(valid8), .owner_cycles(cyc8)
    );
    mux16_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt1), .sel(sel1), .valid(valid1), .owner_cycles(cyc1)
    );
    mux16_rr_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt0), .sel(sel0), .valid(valid0), .owner_cycles(cyc0)
    );
    mux16_1 u_mux (
        .data_in(mux_in), .sel(sel8), .data_out(mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Search from 'start' upward, wrapping; -1 when nobody requests.
    function automatic int first_req(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++) begin
            if (r[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    function automatic mstate_t next_state(input mstate_t s, input logic [15:0] r,
                                           input logic rst, input int hold);
        mstate_t n;
        int      p;
        n = s;
        if (rst) begin
            n.owner = -1; n.sel = 0; n.ptr = 0; n.cyc = 0;
        end else if (s.owner < 0) begin
            p = first_req(r, s.ptr);
            if (p >= 0) begin
                n.owner = p; n.sel = p; n.cyc = 0;
            end
        end else if (!r[s.owner] || (hold != 0 && s.cyc == hold - 1)) begin
            n.ptr = (s.owner + 1) % 16;
            p = first_req(r, n.ptr);
            n.cyc = 0;
            if (p >= 0) begin
                n.owner = p; n.sel = p;
            end else begin
                n.owner = -1;
            end
        end else begin
            n.cyc = (s.cyc < 15) ? s.cyc + 1 : 15;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m8     <= next_state(m8, req, reset, 8);
        m1     <= next_state(m1, req, reset, 1);
        m0     <= next_state(m0, req, reset, 0);
        mux_in <= 16'($urandom);
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int exp_gnt(input mstate_t s);
        return (s.owner < 0) ? 0 : (1 << s.owner);
    endfunction

    task automatic cmp_dut(input string tag, input mstate_t s, input logic [15:0] g,
                           input logic [3:0] sl, input logic v, input logic [3:0] c);
        check({tag, "_gnt"},   int'(g),  exp_gnt(s));
        check({tag, "_sel"},   int'(sl), s.sel);
        check({tag, "_valid"}, int'(v),  (s.owner >= 0) ? 1 : 0);
        check({tag, "_cycles"}, int'(c), s.cyc);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("h8", m8, gnt8, sel8, valid8, cyc8);
            cmp_dut("h1", m1, gnt1, sel1, valid1, cyc1);
            cmp_dut("h0", m0, gnt0, sel0, valid0, cyc0);
            if (valid8) check("mux_out", int'(mux_out), int'(mux_in[sel8]));
        end
    end

    task automatic apply(input logic [15:0] r, input logic rst);
        req   = r;
        reset = rst;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] r;
        vectors = 0;
        fails   = 0;
        chk_en  = 0;
        req     = 16'hFFFF;
        reset   = 1'b1;

        // Reset held with every request high.
        for (int i = 0; i < 2; i++) begin
            apply(16'hFFFF, 1'b1);
            chk_en = 1;
            check("rst_gnt", int'(gnt8), 0);
            check("rst_sel", int'(sel8), 0);
            check("rst_valid", int'(valid8), 0);
        end
        apply(16'hFFFF, 1'b0);
        check("first_gnt", int'(gnt8), 16'h0001);
        check("first_valid", int'(valid8), 1);

        // Single requester for three cycles.
        apply(16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(16'h0010, 1'b0);
            check("single_gnt", int'(gnt8), 16'h0010);
            check("single_sel", int'(sel8), 4);
            check("single_cycles", int'(cyc8), i);
        end
        apply(16'h0000, 1'b0);
        check("single_idle_valid", int'(valid8), 0);
        check("single_idle_gnt", int'(gnt8), 0);
        check("single_idle_sel", int'(sel8), 4);

        // Per-cycle rotation with a hold limit of one.
        apply(16'h0000, 1'b1);
        for (int i = 0; i < 17; i++) begin
            apply(16'hFFFF, 1'b0);
            check("rot_sel", int'(sel1), i % 16);
            check("rot_valid", int'(valid1), 1);
            check("rot_model_sel", m1.sel, i % 16);
        end

        // Two requesters sharing under the hold limit of eight.
        apply(16'h0000, 1'b1);
        for (int i = 0; i < 17; i++) begin
            apply(16'h0003, 1'b0);
            check("hold_sel", int'(sel8), (i / 8) % 2);
            check("hold_cycles", int'(cyc8), i % 8);
        end

        // Owner 14 releases; search wraps past 15 to 0, then on to 5.
        apply(16'h0000, 1'b1);
        apply(16'h4000, 1'b0);
        check("wrap_owner", int'(sel8), 14);
        apply(16'h0021, 1'b0);
        check("wrap_sel0", int'(sel8), 0);
        apply(16'h0020, 1'b0);
        check("wrap_sel5", int'(sel8), 5);

        // Reset in the middle of a tenure.
        apply(16'h0000, 1'b1);
        apply(16'h0200, 1'b0);
        check("midrst_owner", int'(sel8), 9);
        apply(16'h0200, 1'b1);
        check("midrst_gnt", int'(gnt8), 0);
        check("midrst_valid", int'(valid8), 0);
        check("midrst_model_ptr", m8.ptr, 0);
        apply(16'h0200, 1'b0);
        check("midrst_regnt", int'(gnt8), 16'h0200);
        check("midrst_resel", int'(sel8), 9);

        // Unlimited tenure saturates the cycle count.
        apply(16'h0000, 1'b1);
        for (int i = 0; i < 20; i++) apply(16'h0001, 1'b0);
        check("sat_cycles", int'(cyc0), 15);
        check("sat_gnt", int'(gnt0), 16'h0001);

        // Randomised traffic with occasional resets.
        r = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: r = r;
                1: r = 16'($urandom & $urandom);
                2: r = 16'(1 << $urandom_range(0, 15));
                default: r = r & ~16'(1 << $urandom_range(0, 15));
            endcase
            apply(r, ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 bit-select mux (mux16_1) among 16 requesters.
- Registers a one-hot grant and drives the mux's 4-bit select plus a valid qualifier.
- Sits beside the mux in the datapath. Requesters drop req to release; a hold limit bounds tenure.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 to match the mux width.
- SEL_W, 4, select width, log2(N_REQ).
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; 0 = unlimited.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- req  input  16  per-requester request, level, must stay high until granted to be served.
- gnt  output  16  registered one-hot grant; all-zero when idle.
- sel  output  4  registered index of current owner; drives mux16_1 sel.
- valid  output  1  high while any grant is active; qualifies mux16_1 out.
- owner_cycles  output  4  registered count of cycles the current owner has held the grant, 0-based; saturates at 15.

Behaviour:
- Reset (sync, active-high): state=IDLE, gnt=0, sel=0, valid=0, owner_cycles=0, ptr=0. Reset wins over all other events in the same cycle, including mid-tenure; the grant drops on the following edge.
- ptr (4-bit) is the highest-priority index. The search order is ptr, ptr+1, ..., ptr+15, all mod 16, and wraps from 15 to 0.
- States:
  - IDLE: if req!=0, pick the first set bit in search order. Next edge: state=GRANT, gnt=onehot(pick), sel=pick, valid=1, owner_cycles=0. If req==0, stay IDLE.
  - GRANT: release when req[sel]==0, or when MAX_HOLD!=0 and owner_cycles==MAX_HOLD-1.
- On release:
  - ptr <= sel+1 (wraps 15->0).
  - The new pick is computed the same cycle with search start sel+1. The releasing owner is eligible only as the last candidate.
  - If a pick exists, the next edge grants it directly. There is no idle bubble, owner_cycles resets to 0, and valid stays 1.
  - If no pick exists, the next edge goes to IDLE with gnt=0 and valid=0. sel keeps the last owner index so the mux input stays stable.
- No release: gnt, sel and ptr hold. owner_cycles increments and saturates at 15.
- Latency: one cycle from req sampled to gnt visible. Back-to-back handover takes one cycle.
- Requests from non-owners never preempt the current owner.
- A requester that drops req before it is granted is simply skipped. There is no request latching.
- Invariants: gnt is one-hot or zero; valid == |gnt; when valid=1, gnt == onehot(sel).
- MAX_HOLD=1: every grant lasts exactly one cycle, giving pure per-cycle rotation.

Decomposition:
- Package mux_arb_pkg holds: N_REQ=16, SEL_W=4, the state enum (IDLE, GRANT), and a function onehot16(sel) -> logic[15:0].
- Sub-module rr_pick16 is combinational. Inputs are req[15:0] and start[3:0]; outputs are found and idx[3:0]. It implements the rotate, priority encode, and un-rotate.
- The arbiter instantiates one rr_pick16. Its start input is ptr in IDLE and sel+1 in GRANT.
- The bench instantiates mux16_1 driven by sel and checks that mux out equals in[sel] whenever valid=1.

Test Plan:
- Reset: assert reset 2 cycles with req=16'hFFFF -> gnt=0, sel=0, valid=0 throughout. The first grant after deassert goes to index 0.
- Single requester: req=16'h0010 held 3 cycles then dropped, MAX_HOLD=8 -> gnt=16'h0010 and sel=4 for 3 cycles, then IDLE.
- Rotation: all 16 req high, MAX_HOLD=1 -> sel sequence is 0,1,...,15,0 with valid continuously 1.
- Hold limit: req=16'h0003 held continuously, MAX_HOLD=8 -> sel=0 for 8 cycles, then sel=1 for 8, then sel=0. owner_cycles runs 0..7 each tenure.
- Wrap-around and skip: owner is index 14; release with req=16'h0021 -> next grant is sel=0 (wrap past 15), then sel=5.
- Mid-operation reset: reset asserted during a GRANT at sel=9 -> next edge gives gnt=0, valid=0, ptr=0. After deassert with req=16'h0200, the grant goes to sel=9 one cycle later.
